// File: rtl/ps_hooks_regbank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ps_hooks_regbank
// Brief    : AXI4-Lite register bank for PS-to-PL hooks, with RW control regs
//            and RO status regs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module ps_hooks_regbank #(
   parameter int                     C_S_AXI_DATA_WIDTH = 32,
   parameter int                     C_S_AXI_ADDR_WIDTH = 6,
   parameter int                     NUM_CTRL           = 8,
   parameter int                     NUM_STAT           = 4,
   parameter logic [NUM_CTRL*32-1:0] CTRL_RESET         = '0
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_CTRL*32-1:0]          ctrl_out,
   output logic [NUM_CTRL-1:0]             ctrl_wr_pulse,
   input  logic [NUM_STAT*32-1:0]          stat_in
);

   localparam int         c_idx_w       = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_slverr = 2'b10;

   logic                            r_aw_full;
   logic [c_idx_w-1:0]              r_aw_idx;
   logic                            r_w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_w_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] r_w_strb;
   logic                            r_bvalid;
   logic [1:0]                      r_bresp;
   logic [NUM_CTRL-1:0]             r_wr_pulse;
   logic                            r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
   logic [1:0]                      r_rresp;

   logic                            w_aw_hs;
   logic                            w_w_hs;
   logic                            w_ar_hs;
   logic                            w_commit;
   logic                            w_wr_is_ctrl;
   logic [NUM_CTRL-1:0]             w_hit;
   logic [c_idx_w-1:0]              w_ar_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
   logic [1:0]                      w_rd_resp;
   logic                            w_unused;

   assign S_AXI_AWREADY = !r_aw_full && !ARESET;
   assign S_AXI_WREADY  = !r_w_full && !ARESET;
   assign S_AXI_ARREADY = !r_rvalid && !ARESET;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign ctrl_wr_pulse = r_wr_pulse;

   assign w_aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_hs       = S_AXI_WVALID && S_AXI_WREADY;
   assign w_ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
   // An unacknowledged B response blocks the next commit, so holding regs may fill meanwhile.
   assign w_commit     = r_aw_full && r_w_full && !r_bvalid;
   assign w_wr_is_ctrl = int'(r_aw_idx) < NUM_CTRL;
   assign w_ar_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_unused     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_aw_full <= 1'b0;
         r_aw_idx  <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
      end else begin
         if (w_commit) begin
            r_aw_full <= 1'b0;
         end else if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_commit) begin
            r_w_full <= 1'b0;
         end else if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= S_AXI_WDATA;
            r_w_strb <= S_AXI_WSTRB;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_bvalid   <= 1'b0;
         r_bresp    <= c_resp_okay;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= (|r_w_strb) ? w_hit : '0;
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_is_ctrl ? c_resp_okay : c_resp_slverr;
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
      logic [31:0] r_q;

      assign w_hit[k] = w_commit && (int'(r_aw_idx) == k);
      assign ctrl_out[32*k +: 32] = r_q;

      always_ff @(posedge ACLK) begin
         if (ARESET) begin
            r_q <= CTRL_RESET[32*k +: 32];
         end else if (w_hit[k]) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
               if (r_w_strb[b]) r_q[8*b +: 8] <= r_w_data[8*b +: 8];
            end
         end
      end
   end

   // Out-of-range indices fall through to the zero/SLVERR default.
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = c_resp_slverr;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (int'(w_ar_idx) == k) begin
            w_rd_data = ctrl_out[32*k +: 32];
            w_rd_resp = c_resp_okay;
         end
      end
      for (int s = 0; s < NUM_STAT; s++) begin
         if (int'(w_ar_idx) == NUM_CTRL + s) begin
            w_rd_data = stat_in[32*s +: 32];
            w_rd_resp = c_resp_okay;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= c_resp_okay;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_resp;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps_hooks_regbank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_ps_hooks_regbank
// Brief    : Directed self-checking bench for ps_hooks_regbank.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ps_hooks_regbank;

   localparam logic [255:0] TB_CTRL_RESET = {192'h0, 32'h0000_00FF, 32'h0};

   logic         clk;
   logic         rst;
   logic [5:0]   awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [5:0]   araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [2:0]   prot;
   logic [255:0] ctrl_out;
   logic [7:0]   ctrl_wr_pulse;
   logic [127:0] stat_in;

   int           checks;
   int           errors;
   logic [31:0]  exp_ctrl [8];

   ps_hooks_regbank #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (6),
      .NUM_CTRL           (8),
      .NUM_STAT           (4),
      .CTRL_RESET         (TB_CTRL_RESET)
   ) u_dut (
      .ACLK          (clk),
      .ARESET        (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (prot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (prot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .ctrl_out      (ctrl_out),
      .ctrl_wr_pulse (ctrl_wr_pulse),
      .stat_in       (stat_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] exp_vec();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = exp_ctrl[k];
      return v;
   endfunction

   task automatic set_reset_exp();
      for (int k = 0; k < 8; k++) exp_ctrl[k] = 32'h0;
      exp_ctrl[1] = 32'h0000_00FF;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat,
                           output logic [7:0] p_b, output logic [7:0] p_a);
      int   n;
      logic aw_hs;
      logic w_hs;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         step();
         n++;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
      end
      lat = 0;
      while (!bvalid && lat < 50) begin
         step();
         lat++;
      end
      resp = bresp;
      p_b  = ctrl_wr_pulse;
      step();
      p_a  = ctrl_wr_pulse;
   endtask

   task automatic read_check(input string tag, input logic [5:0] a,
                             input logic [31:0] exp_d, input logic [1:0] exp_r);
      int   n;
      logic hs;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arvalid && n < 50) begin
         hs = arready;
         step();
         n++;
         if (hs) arvalid = 1'b0;
      end
      while (!rvalid && n < 50) begin
         step();
         n++;
      end
      check({tag, "_rvalid"}, rvalid, 1'b1);
      check({tag, "_rdata"}, rdata, exp_d);
      check({tag, "_rresp"}, rresp, exp_r);
      step();
   endtask

   initial begin
      logic [1:0] resp;
      int         lat;
      logic [7:0] pb;
      logic [7:0] pa;
      int         n;

      checks = 0; errors = 0;
      rst = 1'b1; prot = 3'b000;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      stat_in = {32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF};
      set_reset_exp();

      // Reset state
      repeat (3) step();
      check("rst_ctrl", ctrl_out, exp_vec());
      check("rst_ctrl1", ctrl_out[63:32], 32'h0000_00FF);
      check("rst_valids", {bvalid, rvalid, ctrl_wr_pulse}, 10'h0);
      check("rst_readys", {awready, wready, arready}, 3'b000);
      rst = 1'b0;
      step();
      check("rel_readys", {awready, wready, arready}, 3'b111);

      // Full-word write and readback
      do_write(6'h00, 32'hA5A5_0001, 4'hF, resp, lat, pb, pa);
      exp_ctrl[0] = 32'hA5A5_0001;
      check("w0_resp", resp, 2'b00);
      check("w0_lat", lat, 1);
      check("w0_pulse", pb, 8'h01);
      check("w0_pulse_end", pa, 8'h00);
      read_check("r0", 6'h00, 32'hA5A5_0001, 2'b00);

      // Byte strobes
      do_write(6'h04, 32'h1122_3344, 4'hF, resp, lat, pb, pa);
      do_write(6'h04, 32'hFFFF_FFFF, 4'b0101, resp, lat, pb, pa);
      exp_ctrl[1] = 32'h11FF_33FF;
      check("w1_pulse", pb, 8'h02);
      read_check("r1", 6'h04, 32'h11FF_33FF, 2'b00);
      do_write(6'h04, 32'h0000_0000, 4'h0, resp, lat, pb, pa);
      check("w1z_resp", resp, 2'b00);
      check("w1z_pulse", pb, 8'h00);
      read_check("r1z", 6'h04, 32'h11FF_33FF, 2'b00);

      // W leads AW by 3 cycles, then AW leads W, with BREADY held low
      bready = 1'b0;
      wdata = 32'h0000_1111; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      check("skew_w_held", {awready, wready}, 2'b10);
      repeat (3) step();
      awaddr = 6'h08; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      step();
      exp_ctrl[2] = 32'h0000_1111;
      check("skew_b1_valid", bvalid, 1'b1);
      check("skew_b1_ctrl", ctrl_out, exp_vec());
      awaddr = 6'h0C; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      wdata = 32'h2222_0000; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      repeat (3) step();
      check("skew_b1_hold", {bvalid, bresp, awready, wready}, 5'b10000);
      check("skew_blocked", ctrl_out, exp_vec());
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("skew_b_gap", bvalid, 1'b0);
      step();
      exp_ctrl[3] = 32'h2222_0000;
      check("skew_b2", {bvalid, bresp, ctrl_wr_pulse}, {1'b1, 2'b00, 8'h08});
      check("skew_b2_ctrl", ctrl_out, exp_vec());
      bready = 1'b1;
      step();

      // Status reads, illegal write and read
      read_check("stat0", 6'h20, 32'hDEAD_BEEF, 2'b00);
      read_check("stat1", 6'h24, 32'h1234_5678, 2'b00);
      do_write(6'h20, 32'h5A5A_5A5A, 4'hF, resp, lat, pb, pa);
      check("wstat_resp", resp, 2'b10);
      check("wstat_pulse", pb, 8'h00);
      check("wstat_ctrl", ctrl_out, exp_vec());
      do_write(6'h3C, 32'h5A5A_5A5A, 4'hF, resp, lat, pb, pa);
      check("woor_resp", resp, 2'b10);
      read_check("roor", 6'h30, 32'h0, 2'b10);
      read_check("r5", 6'h14, 32'h0, 2'b00);

      // AR handshake on the commit edge returns the pre-write value
      awaddr = 6'h18; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b0; rready = 1'b0;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 6'h18; arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      exp_ctrl[6] = 32'hCAFE_F00D;
      check("race_valids", {bvalid, rvalid}, 2'b11);
      check("race_rdata", rdata, 32'h0);
      check("race_ctrl", ctrl_out, exp_vec());
      bready = 1'b1; rready = 1'b1;
      step();

      // Reset with both responses pending and an AW latched
      bready = 1'b0; rready = 1'b0;
      awaddr = 6'h14; awvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      awaddr = 6'h08; awvalid = 1'b1;
      araddr = 6'h00; arvalid = 1'b1;
      step();
      awvalid = 1'b0; arvalid = 1'b0;
      exp_ctrl[5] = 32'h5555_5555;
      check("prerst_valids", {bvalid, rvalid}, 2'b11);
      check("prerst_ctrl", ctrl_out, exp_vec());
      rst = 1'b1;
      step();
      set_reset_exp();
      check("rst2_valids", {bvalid, rvalid, ctrl_wr_pulse}, 10'h0);
      check("rst2_ctrl", ctrl_out, exp_vec());
      rst = 1'b0; bready = 1'b1; rready = 1'b1;
      step();
      wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      repeat (4) step();
      check("post_rst_quiet", {bvalid, rvalid}, 2'b00);
      check("post_rst_ctrl", ctrl_out, exp_vec());
      awaddr = 6'h08; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin
         step();
         n++;
      end
      exp_ctrl[2] = 32'h7777_7777;
      check("post_rst_commit", {bvalid, bresp}, 3'b100);
      check("post_rst_ctrl2", ctrl_out, exp_vec());
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
